// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control, parallel/serial data and status.
// master drives the controls, slave is the register itself.
interface univ_shift_reg_if #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW + 1)
);
  logic          enb;
  logic [2:0]    mode;
  logic [DW-1:0] inp;
  logic          sin_r;
  logic          sin_l;
  logic [DW-1:0] out;
  logic          sout;
  logic [CW-1:0] cnt;
  logic          word_vld;

  modport master (
    output enb, mode, inp, sin_r, sin_l,
    input  out, sout, cnt, word_vld
  );

  modport slave (
    input  enb, mode, inp, sin_r, sin_l,
    output out, sout, cnt, word_vld
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate with a word-completion counter.
// Optional macro UNIV_SHIFT_REG_ROTATE_EN builds ROR/ROL; otherwise those modes act as HOLD.
module univ_shift_reg #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  univ_shift_reg_if.slave    bus
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ROL  = 3'd5
  } op_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  logic [DW-1:0] out_q, out_d;
  logic          sout_q, sout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          word_vld_q, word_vld_d;
  logic          shift_s;
  op_e           op_s;

  // Reserved encodings (and rotates when not built) collapse onto HOLD here.
  function automatic op_e decode_mode(input logic [2:0] mode);
    op_e op;
    case (mode)
      3'b001:  op = OP_LOAD;
      3'b010:  op = OP_SHR;
      3'b011:  op = OP_SHL;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      3'b100:  op = OP_ROR;
      3'b101:  op = OP_ROL;
`endif
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

  // Next-state data path, serial output and word counter.
  always_comb begin
    op_s       = decode_mode(bus.mode);
    out_d      = out_q;
    sout_d     = sout_q;
    cnt_d      = cnt_q;
    word_vld_d = 1'b0;
    shift_s    = 1'b0;
    if (bus.enb) begin
      case (op_s)
        OP_LOAD: begin
          out_d = bus.inp;
          cnt_d = {CW{1'b0}};
        end
        OP_SHR: begin
          out_d   = {bus.sin_r, out_q[DW-1:1]};
          sout_d  = out_q[0];
          shift_s = 1'b1;
        end
        OP_SHL: begin
          out_d   = {out_q[DW-2:0], bus.sin_l};
          sout_d  = out_q[DW-1];
          shift_s = 1'b1;
        end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        OP_ROR: begin
          out_d   = {out_q[0], out_q[DW-1:1]};
          sout_d  = out_q[0];
          shift_s = 1'b1;
        end
        OP_ROL: begin
          out_d   = {out_q[DW-2:0], out_q[DW-1]};
          sout_d  = out_q[DW-1];
          shift_s = 1'b1;
        end
`endif
        default: begin
          out_d = out_q;
        end
      endcase

      // A mode change mid-word keeps counting; only load, completion or reset clear it.
      if (shift_s) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = {CW{1'b0}};
          word_vld_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          word_vld_d = 1'b0;
        end
      end else begin
        word_vld_d = 1'b0;
      end
    end else begin
      word_vld_d = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over enable and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= {DW{1'b0}};
      sout_q     <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      word_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      sout_q     <= sout_d;
      cnt_q      <= cnt_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.sout     = sout_q;
  assign bus.cnt      = cnt_q;
  assign bus.word_vld = word_vld_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (DW = 8): vector table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_univ_shift_reg;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  univ_shift_reg_if #(.DW(8)) bus ();

  univ_shift_reg #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state kept as plain integers.
  int m_out;
  int m_cnt;
  int m_sout;
  int m_vld;
  bit m_valid;

  typedef struct {
    logic       rst;
    logic       enb;
    logic [2:0] mode;
    logic [7:0] inp;
    logic       sr;
    logic       sl;
    logic [7:0] e_out;
    logic       e_sout;
    logic [3:0] e_cnt;
    logic       e_vld;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic model_update();
    int md;
    bit shifted;
    md = int'(bus.mode);
    shifted = 1'b0;
    if (rst) begin
      m_out = 0; m_cnt = 0; m_sout = 0; m_vld = 0; m_valid = 1'b1;
    end else if (!bus.enb) begin
      m_vld = 0;
    end else begin
      m_vld = 0;
      if (md == 1) begin
        m_out = int'(bus.inp); m_cnt = 0;
      end else if (md == 2) begin
        m_sout = m_out % 2; m_out = m_out / 2 + int'(bus.sin_r) * 128; shifted = 1'b1;
      end else if (md == 3) begin
        m_sout = m_out / 128; m_out = (m_out * 2) % 256 + int'(bus.sin_l); shifted = 1'b1;
      end else if (ROT && md == 4) begin
        m_sout = m_out % 2; m_out = m_out / 2 + (m_out % 2) * 128; shifted = 1'b1;
      end else if (ROT && md == 5) begin
        m_sout = m_out / 128; m_out = (m_out * 2) % 256 + m_out / 128; shifted = 1'b1;
      end
      if (shifted) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin
          m_cnt = 0; m_vld = 1;
        end
      end
    end
  endtask

  // One clock: advance the model on the current inputs, then compare after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("m_out",  32'(bus.out),      32'(m_out));
      chk("m_sout", 32'(bus.sout),     32'(m_sout));
      chk("m_cnt",  32'(bus.cnt),      32'(m_cnt));
      chk("m_vld",  32'(bus.word_vld), 32'(m_vld));
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] md,
                       input logic [7:0] d, input logic sr, input logic sl);
    rst = r; bus.enb = e; bus.mode = md; bus.inp = d; bus.sin_r = sr; bus.sin_l = sl;
  endtask

  function automatic void add(input logic r, input logic e, input logic [2:0] md,
                              input logic [7:0] d, input logic sr, input logic sl,
                              input logic [7:0] eo, input logic es, input logic [3:0] ec,
                              input logic ev);
    vec_t v;
    v.rst = r; v.enb = e; v.mode = md; v.inp = d; v.sr = sr; v.sl = sl;
    v.e_out = eo; v.e_sout = es; v.e_cnt = ec; v.e_vld = ev;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] held;
    checks = 0;
    errors = 0;
    m_valid = 1'b0;
    m_out = 0; m_cnt = 0; m_sout = 0; m_vld = 0;

    // Reset, load, SIPO via SHR, PISO via SHL, reserved mode, enable low.
    add(1'b1, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
    add(1'b0, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'hD2, 1'b1, 4'd1, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'h69, 1'b0, 4'd2, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'hB4, 1'b1, 4'd3, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b1, 8'hDA, 1'b0, 4'd4, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'h6D, 1'b0, 4'd5, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'h36, 1'b1, 4'd6, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'h9B, 1'b0, 4'd7, 1'b0);
    add(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'h4D, 1'b1, 4'd0, 1'b1);
    add(1'b0, 1'b1, 3'b001, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 4'd0, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 8'h86, 1'b1, 4'd1, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b1, 4'd2, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 8'h18, 1'b0, 4'd3, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 4'd4, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 8'h60, 1'b0, 4'd5, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 4'd6, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 4'd7, 1'b0);
    add(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1);
    add(1'b0, 1'b1, 3'b111, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 4'd0, 1'b0);
    add(1'b0, 1'b0, 3'b010, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 4'd0, 1'b0);

    // Garbage before reset, no checks while the model is unknown.
    bus.enb = 1'b1; bus.mode = 3'b010; bus.inp = 8'h3C; bus.sin_r = 1'b1; bus.sin_l = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].enb, tbl[i].mode, tbl[i].inp, tbl[i].sr, tbl[i].sl);
      step();
      chk($sformatf("tbl%0d_out", i),  32'(bus.out),      32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_sout", i), 32'(bus.sout),     32'(tbl[i].e_sout));
      chk($sformatf("tbl%0d_cnt", i),  32'(bus.cnt),      32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_vld", i),  32'(bus.word_vld), 32'(tbl[i].e_vld));
    end

    // Enable low stretches a partial word; LOAD aborts it.
    drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    held = bus.out;
    chk("pre_hold_out", 32'(held), 32'hE0);
    bus.enb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_cnt", 32'(bus.cnt), 32'd3);
      chk("hold_out", 32'(bus.out), 32'(held));
      chk("hold_vld", 32'(bus.word_vld), 32'd0);
    end
    drive(1'b0, 1'b1, 3'b001, 8'h12, 1'b0, 1'b0);
    step();
    chk("abort_cnt", 32'(bus.cnt), 32'd0);
    chk("abort_vld", 32'(bus.word_vld), 32'd0);
    drive(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      bus.mode = (i % 3 == 0) ? 3'b010 : 3'b011;
      step();
      chk("b2b_vld", 32'(bus.word_vld), (i == 7 || i == 15) ? 32'd1 : 32'd0);
    end

    // Rotate (or HOLD when rotates are not built).
    drive(1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
    step();
    bus.mode = 3'b100;
    step();
    chk("ror1_out", 32'(bus.out), ROT ? 32'hC0 : 32'h81);
    chk("ror1_sout", 32'(bus.sout), ROT ? 32'd1 : 32'(m_sout));
    chk("ror1_cnt", 32'(bus.cnt), ROT ? 32'd1 : 32'd0);
    for (int i = 0; i < 7; i++) step();
    chk("ror8_out", 32'(bus.out), 32'h81);
    chk("ror8_vld", 32'(bus.word_vld), ROT ? 32'd1 : 32'd0);
    bus.mode = 3'b101;
    for (int i = 0; i < 3; i++) step();

    // Reserved mode, then reset mid-word.
    held = bus.out;
    bus.mode = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rsv_out", 32'(bus.out), 32'(held));
    end
    drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_out", 32'(bus.out), 32'd0);
    chk("mid_rst_cnt", 32'(bus.cnt), 32'd0);
    chk("mid_rst_sout", 32'(bus.sout), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_vld", 32'(bus.word_vld), (i == 7) ? 32'd1 : 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            8'($urandom),
            1'($urandom),
            1'($urandom));
      if ($urandom_range(0, 99) < 60) bus.mode = 3'($urandom_range(2, 5));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
